// File: rtl/branch_ctrl.sv
// -----------------------------------------------------------------------------
// branch_ctrl
//
// Resolves conditional branches in the D stage of a simple in-order pipeline.
// The branch condition is evaluated once both needed operands are final. A
// taken branch produces a one-cycle redirect pulse to the next-PC logic,
// carrying a registered copy of the target. The block also keeps
// resolved/taken statistics and flags a branch found in a delay slot.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   br_valid     branch instruction present in D this cycle
//   B_type[2:0]  0 beq, 1 bne, 2 blez, 3 bgez, 4 bltz, 5 bgtz, 6/7 never taken
//   R1D[31:0]    forwarded rs operand
//   R2D[31:0]    forwarded rt operand
//   rs_ready     rs operand is final
//   rt_ready     rt operand is final (ignored by one-operand branch kinds)
//   target[31:0] branch target computed in D
//   stallD       freezes F and D while a branch waits for its operands
//   redirect     one-cycle pulse, next-PC loads redirect_pc
//   redirect_pc  registered taken target
//   br_cnt       resolved-branch counter, saturating
//   taken_cnt    taken-branch counter, saturating
//   slot_err     sticky: a branch appeared in a delay slot
//
// State table
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   S_IDLE   | no pending branch; evaluates a ready branch immediately
//   S_WAIT   | branch present but an operand is still in flight
//   S_TAKEN  | redirect cycle; an incoming branch here is a delay-slot error
// -----------------------------------------------------------------------------
module branch_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        br_valid,
    input  logic [2:0]  B_type,
    input  logic [31:0] R1D,
    input  logic [31:0] R2D,
    input  logic        rs_ready,
    input  logic        rt_ready,
    input  logic [31:0] target,
    output logic        stallD,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [15:0] br_cnt,
    output logic [15:0] taken_cnt,
    output logic        slot_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_TAKEN = 2'd2
    } state_t;

    localparam logic [2:0] BT_BEQ  = 3'd0;
    localparam logic [2:0] BT_BNE  = 3'd1;
    localparam logic [2:0] BT_BLEZ = 3'd2;
    localparam logic [2:0] BT_BGEZ = 3'd3;
    localparam logic [2:0] BT_BLTZ = 3'd4;
    localparam logic [2:0] BT_BGTZ = 3'd5;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    state_t      state_q,       state_d;
    logic        redirect_q,    redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic [15:0] br_cnt_q,      br_cnt_d;
    logic [15:0] taken_cnt_q,   taken_cnt_d;
    logic        slot_err_q,    slot_err_d;

    logic        ops_ready;
    logic        cond_taken;
    logic        r1_zero;
    logic        r1_neg;
    logic        in_resolve;

    // -------------------------------------------------------------------------
    // Condition evaluation (purely combinational on the current operands)
    // -------------------------------------------------------------------------
    assign r1_zero = (R1D == 32'd0);
    assign r1_neg  = R1D[31];

    always_comb begin
        cond_taken = 1'b0;
        case (B_type)
            BT_BEQ:  cond_taken = (R1D == R2D);
            BT_BNE:  cond_taken = (R1D != R2D);
            BT_BLEZ: cond_taken = r1_neg | r1_zero;
            BT_BGEZ: cond_taken = ~r1_neg;
            BT_BLTZ: cond_taken = r1_neg;
            BT_BGTZ: cond_taken = ~r1_neg & ~r1_zero;
            default: cond_taken = 1'b0;
        endcase
    end

    // Kinds 2 and above read only rs, so an outstanding rt producer must not
    // hold them up.
    assign ops_ready = rs_ready & (rt_ready | (B_type >= 3'd2));

    assign in_resolve = (state_q == S_IDLE) || (state_q == S_WAIT);

    // The stall must hit the fetch stage in the same cycle as the hazard, so
    // it cannot wait for a register stage.
    assign stallD = ~reset & in_resolve & br_valid & ~ops_ready;

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        br_cnt_d      = br_cnt_q;
        taken_cnt_d   = taken_cnt_q;
        slot_err_d    = slot_err_q;

        case (state_q)
            S_IDLE, S_WAIT: begin
                if (br_valid) begin
                    if (ops_ready) begin
                        if (br_cnt_q != CNT_MAX) begin
                            br_cnt_d = br_cnt_q + 16'd1;
                        end
                        if (cond_taken) begin
                            state_d       = S_TAKEN;
                            redirect_d    = 1'b1;
                            redirect_pc_d = target;
                            if (taken_cnt_q != CNT_MAX) begin
                                taken_cnt_d = taken_cnt_q + 16'd1;
                            end
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    // In WAIT this is a flush: the branch is dropped silently.
                    state_d = S_IDLE;
                end
            end

            S_TAKEN: begin
                // The slot instruction is never resolved; only flagged.
                state_d = S_IDLE;
                if (br_valid) begin
                    slot_err_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'd0;
            br_cnt_q      <= 16'd0;
            taken_cnt_q   <= 16'd0;
            slot_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            br_cnt_q      <= br_cnt_d;
            taken_cnt_q   <= taken_cnt_d;
            slot_err_q    <= slot_err_d;
        end
    end

    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign br_cnt      = br_cnt_q;
    assign taken_cnt   = taken_cnt_q;
    assign slot_err    = slot_err_q;

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk input 1 rising-edge clock; reset input 1 synchronous active-high reset.
REQ-002 br_valid  input  1  a branch instruction is present in the D stage this cycle.
REQ-003 B_type  input  3  branch kind:
  - 0 beq, 1 bne, 2 blez, 3 bgez, 4 bltz, 5 bgtz
  - 6 and 7 are never taken.
REQ-004 R1D, R2D  input  32 each  forwarded rs and rt operand values.
REQ-005 rs_ready, rt_ready  input  1 each  the matching operand is final (no pending producer).
REQ-006 target  input  32  branch target address computed in D.
REQ-007 stallD  output  1  freezes the F and D stages.
REQ-008 redirect  output  1  one-cycle pulse; NPC SHALL load redirect_pc.
REQ-009 redirect_pc  output  32  registered taken target.
REQ-010 br_cnt, taken_cnt  output  16 each  resolved-branch counter and taken-branch counter.
REQ-011 slot_err  output  1  sticky flag: a branch was seen in a delay slot.

Function
REQ-012 Condition evaluation SHALL follow REQ-003 and SHALL be combinational on the current inputs:
  - beq/bne compare all 32 bits;
  - blez/bgez/bltz/bgtz compare R1D, signed two's complement, against 0.
REQ-013 The ready term SHALL be rs_ready AND (rt_ready OR B_type>=2); rt_ready SHALL be ignored for one-operand types.
REQ-014 FSM states SHALL be IDLE, WAIT and TAKEN.
REQ-015 IDLE transitions:
  - br_valid & ready: evaluate this cycle; taken -> TAKEN; not taken -> stay in IDLE.
  - br_valid & !ready -> WAIT.
REQ-016 WAIT transitions:
  - br_valid & ready: evaluate exactly as in IDLE.
  - br_valid & !ready: stay in WAIT.
  - !br_valid (flush) -> IDLE, with no evaluation, no counter change and no redirect.
REQ-017 TAKEN SHALL last exactly one cycle, then -> IDLE.
  - redirect=1 throughout TAKEN and 0 in all other states.
  - redirect_pc SHALL hold the target captured on the evaluating edge.
REQ-018 stallD SHALL be br_valid & !ready whenever the state is IDLE or WAIT, and 0 in TAKEN.
REQ-019 stallD is combinational: the fetch stall asserts in the same cycle the hazard is present.
REQ-020 Latency: redirect SHALL assert on the cycle after ready is first seen with br_valid.
REQ-021 Delay slot: in TAKEN, br_valid SHALL NOT be evaluated and SHALL set slot_err=1; slot_err SHALL stay set until reset.
REQ-022 redirect_pc SHALL update only on a taken evaluation and SHALL otherwise hold its value.
REQ-023 Counter updates on an evaluation edge:
  - br_cnt SHALL increment by 1;
  - taken_cnt SHALL also increment when taken.
REQ-024 Both counters SHALL saturate at 16'hFFFF and never wrap.
REQ-025 B_type 6 or 7 SHALL count as resolved and not taken.

Reset
REQ-026 While reset=1 at a rising edge, the next state SHALL be:
  - FSM IDLE;
  - redirect=0, redirect_pc=0;
  - br_cnt=0, taken_cnt=0, slot_err=0.
REQ-027 stallD SHALL be forced to 0 while reset=1.
REQ-028 Reset in WAIT or TAKEN SHALL abandon the pending branch with no redirect.
REQ-029 Reset SHALL take priority over every simultaneous event.

Verification
REQ-030 beq taken: br_valid=1, B_type=0, R1D=R2D=32'h5, both ready, target=32'h3010 -> next cycle redirect=1, redirect_pc=32'h3010; following cycle redirect=0; br_cnt=1, taken_cnt=1.
REQ-031 Hazard then resolve: bne, R1D=1, R2D=2, rt_ready=0 for 3 cycles then 1 -> stallD=1 for exactly 3 cycles, then one redirect pulse.
REQ-032 Signed edge: bgtz with R1D=32'h80000000 -> not taken, no redirect, br_cnt+1; bgez with R1D=0 -> taken. Same for blez/bltz with R1D=0 -> taken/not taken.
REQ-033 Flush in WAIT: enter WAIT, then drop br_valid -> state IDLE, stallD=0, counters unchanged, no redirect.
REQ-034 Delay-slot branch and saturation:
  - br_valid=1 during TAKEN -> slot_err=1 and held, no second redirect;
  - preload 65535 branches -> br_cnt stays 16'hFFFF on the next branch.
REQ-035 Reset mid-WAIT with rs_ready=0 -> stallD=0 during reset, state IDLE, all outputs zero after the edge.
